// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad: queued key codes are "pressed" with optional
// contact chatter, returning the active row to the scanner on its column drive.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 64,
    parameter int GAP_CYCLES    = 64,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] fila,
    output logic       busy,
    output logic       key_done,
    output logic [7:0] done_count
);

    localparam int MAXC_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC    = (MAXC_HG > BOUNCE_CYCLES) ? MAXC_HG : BOUNCE_CYCLES;
    localparam int TW      = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] H_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] B_LAST = TW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          contact_q, contact_d;
    logic [3:0]    key_q;
    logic          pop;
    logic          push;
    logic          done_pulse;

    logic [3:0] mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] occ;

    // Readiness comes from registered occupancy only, so a pop on a full
    // FIFO does not open the door in the same cycle.
    assign key_ready = ~occ[2];
    assign push      = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= key_code;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pop        = 1'b0;
        done_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (occ != 3'd0) begin
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = (BOUNCE_CYCLES > 0) ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN: begin
                if (timer_q == B_LAST) begin
                    timer_d = '0;
                    state_d = HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (timer_q == H_LAST) begin
                    timer_d = '0;
                    state_d = (BOUNCE_CYCLES > 0) ? BOUNCE_OUT : GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BOUNCE_OUT: begin
                if (timer_q == B_LAST) begin
                    timer_d = '0;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (timer_q == G_LAST) begin
                    done_pulse = 1'b1;
                    timer_d    = '0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        // Contact is registered from the upcoming state/index so it lines up
        // exactly with the cycle that state occupies.
        contact_d = (state_d == HOLD)
                 || ((state_d == BOUNCE_IN)  && !timer_d[0])
                 || ((state_d == BOUNCE_OUT) &&  timer_d[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            contact_q  <= 1'b0;
            key_q      <= '0;
            done_count <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            contact_q <= contact_d;
            if (pop) begin
                key_q <= mem[rd_ptr];
            end
            if (done_pulse) begin
                done_count <= done_count + 8'd1;
            end
        end
    end

    always_comb begin
        fila = '0;
        if (contact_q && col[key_q[1:0]]) begin
            fila[key_q[3:2]] = 1'b1;
        end
    end

    assign busy     = (state_q != IDLE) || (occ != 3'd0);
    assign key_done = done_pulse;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench: default-timing instance plus a fast instance (no bounce,
// HOLD=3, GAP=2) for table vectors and the done_count wrap.
module tb_keypad_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst, d_valid, d_ready, d_busy, d_done;
    logic [3:0] d_key, d_col, d_fila;
    logic [7:0] d_cnt;
    logic       f_rst, f_valid, f_ready, f_busy, f_done;
    logic [3:0] f_key, f_col, f_fila;
    logic [7:0] f_cnt;

    keypad_emulator dut_d (
        .clk(clk), .rst(d_rst), .key_code(d_key), .key_valid(d_valid),
        .key_ready(d_ready), .col(d_col), .fila(d_fila), .busy(d_busy),
        .key_done(d_done), .done_count(d_cnt)
    );

    keypad_emulator #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .BOUNCE_CYCLES(0)) dut_f (
        .clk(clk), .rst(f_rst), .key_code(f_key), .key_valid(f_valid),
        .key_ready(f_ready), .col(f_col), .fila(f_fila), .busy(f_busy),
        .key_done(f_done), .done_count(f_cnt)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] fila;
    } vec_t;
    vec_t vecs [8];

    logic       mon_en = 1'b0;
    logic       seen = 1'b0;
    logic [3:0] rows [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (d_fila != 4'b0000 && !seen) begin
                rows.push_back(d_fila);
                seen = 1'b1;
            end
            if (d_done) seen = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected contact for the default timing, j = cycles after the push cycle.
    function automatic logic d_contact(input int j);
        if (j >= 2 && j <= 9)   return ((j - 2) % 2) == 0;
        if (j >= 10 && j <= 73) return 1'b1;
        if (j >= 74 && j <= 81) return ((j - 74) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic d_run(input logic [3:0] key, input logic [3:0] c, input logic [3:0] exp_f);
        d_col = c;
        d_key = key;
        d_valid = 1'b1;
        #1;
        chk("d_push_ready", d_ready, 1'b1);
        tick();
        d_valid = 1'b0;
        for (int j = 1; j <= 145; j++) begin
            chk("d_fila", d_fila, d_contact(j) ? exp_f : 4'b0000);
            chk("d_key_done", d_done, (j == 145));
            if (j < 145) tick();
        end
        tick();
        chk("d_idle_busy", d_busy, 1'b0);
    endtask

    task automatic f_run(input vec_t v, input logic [7:0] exp_cnt);
        f_col = v.col;
        f_key = v.key;
        f_valid = 1'b1;
        #1;
        chk("f_push_ready", f_ready, 1'b1);
        tick();
        f_valid = 1'b0;
        chk("f_busy", f_busy, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            chk("f_fila", f_fila, (j >= 2 && j <= 4) ? v.fila : 4'b0000);
            chk("f_key_done", f_done, (j == 6));
            if (j < 6) tick();
        end
        tick();
        chk("f_busy_end", f_busy, 1'b0);
        chk("f_done_count", f_cnt, exp_cnt);
    endtask

    initial begin
        logic [3:0] keys6 [6];
        logic [3:0] exp_rows [6];
        int n;
        int accepted;
        int pulses;
        logic bad;

        vecs[0] = '{key: 4'b0000, col: 4'b0001, fila: 4'b0001};
        vecs[1] = '{key: 4'b1001, col: 4'b0010, fila: 4'b0100};
        vecs[2] = '{key: 4'b1001, col: 4'b0001, fila: 4'b0000};
        vecs[3] = '{key: 4'b1111, col: 4'b1000, fila: 4'b1000};
        vecs[4] = '{key: 4'b0110, col: 4'b1111, fila: 4'b0010};
        vecs[5] = '{key: 4'b1011, col: 4'b0000, fila: 4'b0000};
        vecs[6] = '{key: 4'b0111, col: 4'b0111, fila: 4'b0000};
        vecs[7] = '{key: 4'b1100, col: 4'b0011, fila: 4'b1000};

        keys6    = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0001, 4'b0110};
        exp_rows = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        d_rst = 1'b1; d_valid = 1'b0; d_key = '0; d_col = 4'b1111;
        f_rst = 1'b1; f_valid = 1'b0; f_key = '0; f_col = 4'b1111;
        tick();
        tick();
        d_rst = 1'b0;
        f_rst = 1'b0;
        #1;
        chk("rst_d_ready", d_ready, 1'b1);
        chk("rst_d_busy", d_busy, 1'b0);
        chk("rst_d_fila", d_fila, 4'b0000);
        chk("rst_d_done", d_done, 1'b0);
        chk("rst_d_cnt", d_cnt, 8'd0);
        chk("rst_f_ready", f_ready, 1'b1);
        chk("rst_f_busy", f_busy, 1'b0);
        chk("rst_f_cnt", f_cnt, 8'd0);

        for (int i = 0; i < 8; i++) begin
            f_run(vecs[i], 8'(i + 1));
        end

        d_run(4'b1001, 4'b0010, 4'b0100);
        chk("d_cnt_1", d_cnt, 8'd1);
        d_run(4'b1001, 4'b0001, 4'b0000);
        chk("d_cnt_2", d_cnt, 8'd2);

        // Back-to-back pushes: five fit, the sixth waits for the first pop
        // after key 0 finishes (ready again 147 cycles after the first push).
        d_col = 4'b1111;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_key = keys6[i];
            d_valid = 1'b1;
            #1;
            chk("d_b2b_ready", d_ready, 1'b1);
            tick();
        end
        d_key = keys6[5];
        n = 0;
        while (!d_ready && n < 400) begin
            tick();
            n++;
        end
        chk("d_full_wait", n, 142);
        tick();
        d_valid = 1'b0;
        n = 0;
        while (d_busy && n < 1500) begin
            tick();
            n++;
        end
        chk("d_drain", d_busy, 1'b0);
        mon_en = 1'b0;
        chk("d_order_len", rows.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rows.size()) chk("d_order", rows[i], exp_rows[i]);
        end
        chk("d_cnt_8", d_cnt, 8'd8);

        // Reset mid-hold with two keys queued; a push during reset is dropped.
        d_col = 4'b0010;
        d_key = 4'b1001;
        d_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        d_valid = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("d_hold_pre", d_fila, 4'b0100);
        d_rst = 1'b1;
        d_valid = 1'b1;
        tick();
        d_rst = 1'b0;
        d_valid = 1'b0;
        #1;
        chk("d_rst_fila", d_fila, 4'b0000);
        chk("d_rst_busy", d_busy, 1'b0);
        chk("d_rst_cnt", d_cnt, 8'd0);
        chk("d_rst_ready", d_ready, 1'b1);
        chk("d_rst_done", d_done, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (d_fila != 4'b0000 || d_busy) bad = 1'b1;
            tick();
        end
        chk("d_rst_quiet", bad, 1'b0);

        // done_count wrap after 256 completions.
        f_rst = 1'b1;
        tick();
        f_rst = 1'b0;
        f_col = 4'b0001;
        f_key = 4'b0000;
        f_valid = 1'b1;
        accepted = 0;
        pulses = 0;
        n = 0;
        while (accepted < 256 && n < 5000) begin
            if (f_ready) accepted++;
            if (f_done) pulses++;
            tick();
            n++;
        end
        f_valid = 1'b0;
        n = 0;
        while (f_busy && n < 3000) begin
            if (f_done) pulses++;
            tick();
            n++;
        end
        chk("f_wrap_accepted", accepted, 256);
        chk("f_wrap_drain", f_busy, 1'b0);
        chk("f_wrap_pulses", pulses, 256);
        chk("f_wrap_cnt", f_cnt, 8'd0);
        f_run(vecs[0], 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
